button_conditioner: RTL and testbench



---
 rtl/button_conditioner_if.sv | 21 ++
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw active-low buttons in, conditioned command pulses and held levels out.
`timescale 1ns/1ps
interface button_conditioner_if;
    logic       btn_increment;
    logic       btn_decrement;
    logic       btn_reset;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       rst_pulse;
    logic [2:0] pressed;

    modport master (
        output btn_increment, btn_decrement, btn_reset,
        input  inc_pulse, dec_pulse, rst_pulse, pressed
    );

    modport slave (
        input  btn_increment, btn_decrement, btn_reset,
        output inc_pulse, dec_pulse, rst_pulse, pressed
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces three active-low buttons, then arbitrates the accepted
// presses into mutually exclusive single-cycle command pulses.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_conditioner_if.slave   bus
);

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 1 of the encoding is the debounced "held" level.
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_e;

    logic [NCH-1:0]         raw_c;
    logic [NCH-1:0]         s_c;
    logic [NCH-1:0]         acc_c;
    logic [SYNC_STAGES-1:0] sync_q  [NCH];
    logic [SYNC_STAGES-1:0] sync_d  [NCH];
    state_e                 state_q [NCH];
    state_e                 state_d [NCH];
    logic [CW-1:0]          cnt_q   [NCH];
    logic [CW-1:0]          cnt_d   [NCH];
    logic                   inc_pulse_q, inc_pulse_d;
    logic                   dec_pulse_q, dec_pulse_d;
    logic                   rst_pulse_q, rst_pulse_d;

    assign raw_c = {bus.btn_reset, bus.btn_decrement, bus.btn_increment};

    // Shift chain per channel; s = 1 means the synchronised button is pressed.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_c[i]};
            s_c[i]    = ~sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i]  <= '1;
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            rst_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i]  <= sync_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            inc_pulse_q <= inc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
            rst_pulse_q <= rst_pulse_d;
        end
    end

    // Debounce FSM: a new level must persist DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    if (s_c[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_c[i])                 state_d[i] = RELEASED;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = HELD;
                    else                         cnt_d[i]   = cnt_q[i] + CNT_ONE;
                end
                HELD: begin
                    if (!s_c[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_c[i])                  state_d[i] = HELD;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = RELEASED;
                    else                         cnt_d[i]   = cnt_q[i] + CNT_ONE;
                end
                default: state_d[i] = RELEASED;
            endcase
        end
    end

    // Accept strobes and arbitration: reset wins, simultaneous inc+dec cancel.
    always_comb begin
        inc_pulse_d = 1'b0;
        dec_pulse_d = 1'b0;
        rst_pulse_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            acc_c[i] = (state_q[i] == PRESS_WAIT) && s_c[i] && (cnt_q[i] == CNT_LAST);
        end
        if (acc_c[2]) begin
            rst_pulse_d = 1'b1;
        end else if (!(acc_c[0] && acc_c[1])) begin
            inc_pulse_d = acc_c[0];
            dec_pulse_d = acc_c[1];
        end
    end

    assign bus.inc_pulse = inc_pulse_q;
    assign bus.dec_pulse = dec_pulse_q;
    assign bus.rst_pulse = rst_pulse_q;
    assign bus.pressed   = {state_q[2][1], state_q[1][1], state_q[0][1]};

endmodule

// File: tb/tb_button_conditioner.sv
// Scenario bench for button_conditioner: expected pulses are queued with their cycle
// when a button is driven and matched by a pulse monitor.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int unsigned DEB  = 8;
    localparam int unsigned SYNC = 2;
    localparam int          LAT  = 10;

    typedef struct {
        int       cyc;
        logic [2:0] kind;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [2:0] kind);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic check_pressed(input string name, input logic [2:0] exp);
        tests_run++;
        if (bus.pressed !== exp) begin
            tests_failed++;
            $display("FAIL %s: pressed=%b required %b (cycle %0d)", name, bus.pressed, exp, cyc);
        end
    endtask

    task automatic check_pending(input string name);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d expected pulse(s) never seen, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic monitor_pulses();
        logic [2:0] k;
        logic [2:0] prev;
        exp_t e;
        prev = 3'b000;
        forever begin
            @(negedge clk);
            k = {bus.rst_pulse, bus.dec_pulse, bus.inc_pulse};
            if (k != 3'b000) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_pulse: got {rst,dec,inc}=%b at cycle %0d, required none", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.kind || cyc != e.cyc) begin
                        tests_failed++;
                        $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", k, cyc, e.kind, e.cyc);
                    end
                end
                tests_run++;
                if ((k & prev) != 3'b000) begin
                    tests_failed++;
                    $display("FAIL pulse_width: %b high two cycles running at cycle %0d, required single cycle", k, cyc);
                end
            end
            prev = k;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        tests_run++;
        if ({bus.rst_pulse, bus.dec_pulse, bus.inc_pulse} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b required 000", {bus.rst_pulse, bus.dec_pulse, bus.inc_pulse});
        end
        check_pressed("reset_pressed", 3'b000);
        rst_n = 1'b1;
        tick(5);
        check_pressed("idle_pressed", 3'b000);
    endtask

    task automatic test_single_press();
        bus.btn_increment = 1'b0;
        expect_pulse(3'b001);
        tick(9);
        check_pressed("single_before_accept", 3'b000);
        tick(1);
        check_pressed("single_held", 3'b001);
        tick(10);
        bus.btn_increment = 1'b1;
        tick(9);
        check_pressed("single_release_wait", 3'b001);
        tick(1);
        check_pressed("single_released", 3'b000);
        check_pending("single_press");
    endtask

    task automatic test_glitches();
        int lens[3] = '{3, 5, 7};
        foreach (lens[i]) begin
            bus.btn_decrement = 1'b0;
            tick(lens[i]);
            bus.btn_decrement = 1'b1;
            tick(2);
        end
        check_pressed("glitch_pressed", 3'b000);
        bus.btn_decrement = 1'b0;
        expect_pulse(3'b010);
        tick(12);
        check_pressed("glitch_steady_held", 3'b010);
        bus.btn_decrement = 1'b1;
        tick(12);
        check_pending("glitch_steady");
    endtask

    task automatic test_collision();
        bus.btn_increment = 1'b0;
        bus.btn_decrement = 1'b0;
        tick(12);
        check_pressed("collision_held", 3'b011);
        bus.btn_increment = 1'b1;
        bus.btn_decrement = 1'b1;
        tick(12);
        check_pending("collision_cancel");
        bus.btn_increment = 1'b0;
        expect_pulse(3'b001);
        tick(12);
        bus.btn_increment = 1'b1;
        tick(12);
        check_pending("collision_then_inc");
    endtask

    task automatic test_priority();
        bus.btn_reset     = 1'b0;
        bus.btn_increment = 1'b0;
        expect_pulse(3'b100);
        tick(14);
        check_pressed("priority_held", 3'b101);
        bus.btn_reset     = 1'b1;
        bus.btn_increment = 1'b1;
        tick(12);
        check_pending("priority_reset_wins");
    endtask

    task automatic test_reset_midpress();
        bus.btn_increment = 1'b0;
        tick(7);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.rst_pulse, bus.dec_pulse, bus.inc_pulse, bus.pressed} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL midpress_async_clear: outputs=%b required 000000",
                     {bus.rst_pulse, bus.dec_pulse, bus.inc_pulse, bus.pressed});
        end
        tick(3);
        rst_n = 1'b1;
        expect_pulse(3'b001);
        tick(12);
        check_pressed("midpress_held_after_reset", 3'b001);
        bus.btn_increment = 1'b1;
        tick(12);
        check_pending("midpress_repress");
    endtask

    task automatic test_bounce_hold();
        bus.btn_increment = 1'b0;
        expect_pulse(3'b001);
        tick(40);
        repeat (4) begin
            bus.btn_increment = 1'b1;
            tick(1);
            bus.btn_increment = 1'b0;
            tick(5);
        end
        tick(36);
        check_pressed("bounce_still_held", 3'b001);
        bus.btn_increment = 1'b1;
        tick(12);
        check_pressed("bounce_released", 3'b000);
        check_pending("bounce_single_pulse");
        bus.btn_increment = 1'b0;
        expect_pulse(3'b001);
        tick(12);
        bus.btn_increment = 1'b1;
        tick(12);
        check_pending("bounce_second_press");
    endtask

    initial begin
        bus.btn_increment = 1'b1;
        bus.btn_decrement = 1'b1;
        bus.btn_reset     = 1'b1;
        fork
            monitor_pulses();
        join_none
        test_reset();
        test_single_press();
        test_glitches();
        test_collision();
        test_priority();
        test_reset_midpress();
        test_bounce_hold();
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
